reimu_shot: RTL and testbench

Player shot manager for the shooter core. It sits directly downstream of the player-position block and consumes its registered `reimux`/`reimuy`. While the fire key is held, it spawns shots at the player's muzzle, moves every live shot up the playfield once per `clk22` tick, and retires shots that leave the top edge or are reported hit. Its slot outputs feed the renderer and the enemy-collision logic.

---
 rtl/reimu_shot.sv | 107 ++++++++++
 tb/tb_reimu_shot.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reimu_shot.sv
// Player shot manager: spawns shots at the player muzzle while fire is held,
// moves live shots up SPEED pixels per tick, retires them at the top edge or on hit.
// Latency: 1 clk22 tick from sampled inputs to registered outputs; no backpressure (fire with no free slot just waits).
//
// Ports:
//   clk22       game tick clock
//   rst         synchronous active-high reset
//   gameover    synchronous clear, same effect as rst
//   fire        fire key held (level)
//   reimux/y    player position, registered upstream
//   hit         per-slot hit from collision logic (ignored on dead slots)
//   shot_valid  per-slot live flag
//   shot_x/y    per-slot position, slot i at bits [10i+9:10i]
//   shot_fired  one-tick pulse on the tick a shot spawns
module reimu_shot #(
  parameter int NSHOT    = 4,
  parameter int SPEED    = 10,
  parameter int COOLDOWN = 3,
  parameter int OFFSET   = 16,
  parameter int TOPY     = 25
) (
  input  logic                clk22,
  input  logic                rst,
  input  logic                gameover,
  input  logic                fire,
  input  logic [9:0]          reimux,
  input  logic [9:0]          reimuy,
  input  logic [NSHOT-1:0]    hit,
  output logic [NSHOT-1:0]    shot_valid,
  output logic [10*NSHOT-1:0] shot_x,
  output logic [10*NSHOT-1:0] shot_y,
  output logic                shot_fired
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  localparam logic [9:0]    EXIT_LIM = 10'(TOPY + SPEED);
  localparam logic [9:0]    SPD      = 10'(SPEED);
  localparam logic [9:0]    OFS      = 10'(OFFSET);
  localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN);
  localparam logic [CW-1:0] CD_ONE   = CW'(1);

  logic [CW-1:0]        cooldown;
  logic [CW-1:0]        cooldown_n;
  logic [NSHOT-1:0]     valid_n;
  logic [10*NSHOT-1:0]  x_n;
  logic [10*NSHOT-1:0]  y_n;
  logic                 spawn;

  always_comb begin
    valid_n = shot_valid;
    x_n     = shot_x;
    y_n     = shot_y;
    spawn   = 1'b0;

    // Movement and retirement of slots that are live at the start of the tick.
    // Retired slots keep their last x/y so the renderer sees no jump.
    for (int i = 0; i < NSHOT; i++) begin
      if (shot_valid[i]) begin
        if (hit[i]) begin
          valid_n[i] = 1'b0;
        end else if (shot_y[10*i +: 10] < EXIT_LIM) begin
          valid_n[i] = 1'b0;
        end else begin
          y_n[10*i +: 10] = shot_y[10*i +: 10] - SPD;
        end
      end
    end

    // Lowest-index free slot wins. Freedom is judged on the start-of-tick
    // valid bits, so a slot retired this tick is only reusable next tick.
    for (int i = 0; i < NSHOT; i++) begin
      if (fire && (cooldown == '0) && !spawn && !shot_valid[i]) begin
        spawn           = 1'b1;
        valid_n[i]      = 1'b1;
        x_n[10*i +: 10] = reimux;
        y_n[10*i +: 10] = reimuy - OFS;
      end
    end

    // A blocked fire (no free slot) leaves the counter parked at zero.
    if (spawn) begin
      cooldown_n = CD_LOAD;
    end else if (cooldown != '0) begin
      cooldown_n = cooldown - CD_ONE;
    end else begin
      cooldown_n = cooldown;
    end
  end

  always_ff @(posedge clk22) begin
    if (rst || gameover) begin
      shot_valid <= '0;
      shot_x     <= '0;
      shot_y     <= '0;
      shot_fired <= 1'b0;
      cooldown   <= '0;
    end else begin
      shot_valid <= valid_n;
      shot_x     <= x_n;
      shot_y     <= y_n;
      shot_fired <= spawn;
      cooldown   <= cooldown_n;
    end
  end

endmodule

// File: tb/tb_reimu_shot.sv
module tb_reimu_shot;

  localparam int NSHOT = 4;

  logic                 clk22 = 1'b0;
  logic                 rst;
  logic                 gameover;
  logic                 fire;
  logic [9:0]           reimux;
  logic [9:0]           reimuy;
  logic [NSHOT-1:0]     hit;
  logic [NSHOT-1:0]     shot_valid;
  logic [10*NSHOT-1:0]  shot_x;
  logic [10*NSHOT-1:0]  shot_y;
  logic                 shot_fired;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk22 = ~clk22;

  reimu_shot #(
    .NSHOT(4), .SPEED(10), .COOLDOWN(3), .OFFSET(16), .TOPY(25)
  ) dut (
    .clk22      (clk22),
    .rst        (rst),
    .gameover   (gameover),
    .fire       (fire),
    .reimux     (reimux),
    .reimuy     (reimuy),
    .hit        (hit),
    .shot_valid (shot_valid),
    .shot_x     (shot_x),
    .shot_y     (shot_y),
    .shot_fired (shot_fired)
  );

  task automatic chk(input string tag, input longint observed, input longint expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One rising edge, then sample 1 time unit later, well clear of the edge.
  task automatic step();
    @(posedge clk22);
    #1;
  endtask

  function automatic longint sx(input int i);
    return longint'(shot_x[10*i +: 10]);
  endfunction

  function automatic longint sy(input int i);
    return longint'(shot_y[10*i +: 10]);
  endfunction

  initial begin
    rst = 1'b1; gameover = 1'b0; fire = 1'b0;
    reimux = '0; reimuy = 10'd25; hit = '0;

    // Power-on reset
    step();
    chk("init_valid", shot_valid, 0);
    chk("init_fired", shot_fired, 0);
    chk("init_x", shot_x, 0);
    chk("init_y", shot_y, 0);
    rst = 1'b0;

    // Cadence: spawn every 4 ticks, shots climb 10 px/tick
    reimux = 10'd220; reimuy = 10'd360; fire = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("cad_fired", shot_fired, (k == 1 || k == 5 || k == 9 || k == 13) ? 1 : 0);
      if (k == 1) begin
        chk("cad1_valid", shot_valid, 4'b0001);
        chk("cad1_s0x", sx(0), 220);
        chk("cad1_s0y", sy(0), 344);
      end
      if (k == 5) begin
        chk("cad5_valid", shot_valid, 4'b0011);
        chk("cad5_s0y", sy(0), 304);
        chk("cad5_s1x", sx(1), 220);
        chk("cad5_s1y", sy(1), 344);
      end
      if (k == 9) begin
        chk("cad9_valid", shot_valid, 4'b0111);
        chk("cad9_s0y", sy(0), 264);
        chk("cad9_s2y", sy(2), 344);
      end
      if (k == 13) begin
        chk("cad13_valid", shot_valid, 4'b1111);
        chk("cad13_s0y", sy(0), 224);
        chk("cad13_s3y", sy(3), 344);
      end
    end

    // Full slots: cooldown expires at tick 16, tick 17 has nowhere to spawn
    for (int k = 14; k <= 17; k++) begin
      step();
      chk("full_fired", shot_fired, 0);
      chk("full_valid", shot_valid, 4'b1111);
    end
    reimux = 10'd100; reimuy = 10'd200; hit = 4'b0010;
    step();
    chk("full_hit_valid", shot_valid, 4'b1101);
    chk("full_hit_fired", shot_fired, 0);
    chk("full_hit_s1x_held", sx(1), 220);
    chk("full_hit_s1y_held", sy(1), 224);
    chk("full_hit_s0y", sy(0), 174);
    hit = '0;
    step();
    chk("respawn_valid", shot_valid, 4'b1111);
    chk("respawn_fired", shot_fired, 1);
    chk("respawn_s1x", sx(1), 100);
    chk("respawn_s1y", sy(1), 184);

    // Reset with all slots live; fire held across two reset edges must not spawn
    rst = 1'b1; fire = 1'b1;
    step();
    chk("rst_valid", shot_valid, 0);
    chk("rst_x", shot_x, 0);
    chk("rst_y", shot_y, 0);
    chk("rst_fired", shot_fired, 0);
    step();
    chk("rst2_valid", shot_valid, 0);
    chk("rst2_fired", shot_fired, 0);
    rst = 1'b0; fire = 1'b0;

    // Top exit from y=35: moves to 25, then retires holding position
    reimux = 10'd50; reimuy = 10'd51; fire = 1'b1;
    step();
    chk("top35_spawn_y", sy(0), 35);
    chk("top35_fired", shot_fired, 1);
    fire = 1'b0; hit = 4'b1110;  // hits on dead slots are ignored
    step();
    chk("top35_move_valid", shot_valid, 4'b0001);
    chk("top35_move_y", sy(0), 25);
    hit = '0;
    step();
    chk("top35_exit_valid", shot_valid, 0);
    chk("top35_exit_y", sy(0), 25);
    chk("top35_exit_x", sx(0), 50);
    step();
    // Top exit from y=34: retires on the very next edge
    reimux = 10'd60; reimuy = 10'd50; fire = 1'b1;
    step();
    chk("top34_spawn_y", sy(0), 34);
    chk("top34_spawn_valid", shot_valid, 4'b0001);
    fire = 1'b0;
    step();
    chk("top34_exit_valid", shot_valid, 0);
    chk("top34_exit_y", sy(0), 34);
    chk("top34_exit_x", sx(0), 60);
    step();
    step();

    // Hit and reuse
    reimux = 10'd200; reimuy = 10'd400; fire = 1'b1;
    for (int k = 1; k <= 13; k++) step();
    chk("hr_fill_valid", shot_valid, 4'b1111);
    fire = 1'b0; hit = 4'b0100;
    step();
    chk("hr_free2_valid", shot_valid, 4'b1011);
    hit = '0;
    step();
    step();
    reimux = 10'd300; reimuy = 10'd300; fire = 1'b1; hit = 4'b0010;
    step();
    chk("hr_swap_valid", shot_valid, 4'b1101);
    chk("hr_swap_fired", shot_fired, 1);
    chk("hr_swap_s2x", sx(2), 300);
    chk("hr_swap_s2y", sy(2), 284);
    hit = '0; reimux = 10'd310; reimuy = 10'd310;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hr_cool_fired", shot_fired, 0);
    end
    step();
    chk("hr_reuse_valid", shot_valid, 4'b1111);
    chk("hr_reuse_fired", shot_fired, 1);
    chk("hr_reuse_s1x", sx(1), 310);
    chk("hr_reuse_s1y", sy(1), 294);
    chk("hr_reuse_s0y", sy(0), 184);

    // Gameover mid-flight with cooldown at 2
    fire = 1'b0; hit = 4'b1000;
    step();
    chk("go_pre_valid", shot_valid, 4'b0111);
    hit = '0; gameover = 1'b1;
    step();
    chk("go_valid", shot_valid, 0);
    chk("go_x", shot_x, 0);
    chk("go_y", shot_y, 0);
    chk("go_fired", shot_fired, 0);
    gameover = 1'b0; fire = 1'b1; reimux = 10'd123; reimuy = 10'd456;
    step();
    chk("go_spawn_valid", shot_valid, 4'b0001);
    chk("go_spawn_fired", shot_fired, 1);
    chk("go_spawn_x", sx(0), 123);
    chk("go_spawn_y", sy(0), 440);
    fire = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
